// File: rtl/seven_by_three_divider_if.sv
// Handshake and operand/result bundle for the sequential 7-by-3 restoring divider.
// The requester uses the master modport and the divider uses the slave modport.
interface seven_by_three_divider_if #(
  parameter int DW = 7,
  parameter int VW = 3
);
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );
endinterface

// File: rtl/seven_by_three_divider.sv
// Sequential restoring divider: DW-bit dividend / VW-bit divisor, one quotient bit per clock,
// MSB first, with a start/busy/done handshake and all outputs registered.
module seven_by_three_divider #(
  parameter int DW = 7,
  parameter int VW = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  seven_by_three_divider_if.slave bus
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e        state_q;
  // dvd_q shifts dividend bits out at the top while quotient bits enter at the bottom.
  logic [DW-1:0] dvd_q;
  logic [VW-1:0] dvs_q;
  logic [VW:0]   rem_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;
  logic          div_zero_q;
  logic [DW-1:0] quotient_q;
  logic [VW-1:0] remainder_q;

  logic [VW:0]   shift_d;
  logic          qbit_d;
  logic [VW:0]   rem_d;
  logic [DW-1:0] dvd_d;

  // One restoring step; rem_q is always below the divisor, so its top bit is always zero.
  always_comb begin
    shift_d = {rem_q[VW-1:0], dvd_q[DW-1]};
    qbit_d  = (shift_d >= {1'b0, dvs_q});
    rem_d   = qbit_d ? (shift_d - {1'b0, dvs_q}) : shift_d;
    dvd_d   = {dvd_q[DW-2:0], qbit_d};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      div_zero_q  <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            busy_q <= 1'b1;
            if (bus.divisor == '0) begin
              quotient_q  <= '1;
              remainder_q <= '0;
              div_zero_q  <= 1'b1;
              state_q     <= DONE;
            end else begin
              dvd_q   <= bus.dividend;
              dvs_q   <= bus.divisor;
              rem_q   <= '0;
              cnt_q   <= '0;
              state_q <= CALC;
            end
          end
        end

        CALC: begin
          dvd_q <= dvd_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(DW - 1)) begin
            quotient_q  <= dvd_d;
            remainder_q <= rem_d[VW-1:0];
            div_zero_q  <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end
        end

        DONE: begin
          // A divide-by-zero arrives here with done low and raises it one edge later.
          if (done_q) begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            done_q <= 1'b1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.div_zero  = div_zero_q;

endmodule

// File: tb/tb_seven_by_three_divider.sv
// Directed self-checking bench for seven_by_three_divider: results, latency, busy span,
// divide-by-zero, ignored restarts and a reset abort, all against hand-computed values.
module tb_seven_by_three_divider;

  localparam int DW = 7;
  localparam int VW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  seven_by_three_divider_if #(.DW(DW), .VW(VW)) bus ();

  seven_by_three_divider #(.DW(DW), .VW(VW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drive one start pulse; returns #1 after the edge that samples it.
  task automatic start_op(input int dvd, input int dvs);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = DW'(dvd);
    bus.divisor  = VW'(dvs);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Counts edges until done (bounded) and the sampled cycles with busy high, including the current one.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = bus.busy ? 1 : 0;
    while (!bus.done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.busy) bcnt++;
    end
  endtask

  task automatic run_op(input string tag, input int dvd, input int dvs,
                        input int exp_q, input int exp_r, input int exp_z,
                        input int exp_lat, input int exp_busy);
    int lat;
    int bcnt;
    start_op(dvd, dvs);
    wait_done(lat, bcnt);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy cycles"}, bcnt, exp_busy);
    check({tag, " quotient"}, int'(bus.quotient), exp_q);
    check({tag, " remainder"}, int'(bus.remainder), exp_r);
    check({tag, " div_zero"}, int'(bus.div_zero), exp_z);
    @(posedge clk);
    #1;
    check({tag, " done pulse width"}, int'(bus.done), 0);
    check({tag, " busy release"}, int'(bus.busy), 0);
  endtask

  initial begin
    int lat;
    int bcnt;
    int seen_done;

    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset busy", int'(bus.busy), 0);
    check("reset done", int'(bus.done), 0);
    check("reset quotient", int'(bus.quotient), 0);
    check("reset remainder", int'(bus.remainder), 0);
    check("reset div_zero", int'(bus.div_zero), 0);

    run_op("15/5", 15, 5, 3, 0, 0, 7, 8);

    // Back-to-back: run_op returns in the first IDLE cycle, so each start lands there.
    run_op("36/3", 36, 3, 12, 0, 0, 7, 8);
    run_op("36/4", 36, 4, 9, 0, 0, 7, 8);
    run_op("40/5", 40, 5, 8, 0, 0, 7, 8);

    run_op("100/7", 100, 7, 14, 2, 0, 7, 8);
    run_op("127/1", 127, 1, 127, 0, 0, 7, 8);
    run_op("6/7", 6, 7, 0, 6, 0, 7, 8);

    run_op("55/0", 55, 0, 127, 0, 1, 1, 2);
    run_op("0/5", 0, 5, 0, 0, 0, 7, 8);

    // Restart attempt at the third cycle of a running division must be ignored.
    start_op(100, 7);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    start_op(9, 3);
    wait_done(lat, bcnt);
    check("ignored start latency", lat, 4);
    check("ignored start quotient", int'(bus.quotient), 14);
    check("ignored start remainder", int'(bus.remainder), 2);
    @(posedge clk);
    #1;

    // Reset in the middle of a division aborts it without a done.
    start_op(51, 6);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort busy", int'(bus.busy), 0);
    check("abort done", int'(bus.done), 0);
    check("abort quotient", int'(bus.quotient), 0);
    check("abort remainder", int'(bus.remainder), 0);
    check("abort div_zero", int'(bus.div_zero), 0);
    seen_done = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) seen_done = 1;
    end
    check("abort no done", seen_done, 0);

    run_op("21/3", 21, 3, 7, 0, 0, 7, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
